// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divide issue sequencer and its request FIFO.
package div_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_BUSY,
    S_RESULT,
    S_DRAIN
  } div_seq_state_t;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] DIV_ZERO_Q       = 32'hFFFF_FFFF;

  // Tag field width carried in the request struct; bounds the top's TAG_W.
  localparam int DIV_TAG_W = 5;

  typedef struct packed {
    logic                 signed_op;
    logic [31:0]          rs1;
    logic [31:0]          rs2;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divide sequencer; extra pointer MSB separates full from empty.
module div_req_fifo
  import div_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     clear,
  input  logic     push,
  input  logic     pop,
  input  div_req_t din,
  output div_req_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  div_req_t   mem [DEPTH];
  logic [AW:0] wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= din;
        wptr <= wptr + 1'b1;
      end
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/div_issue_sequencer.sv
// Queues DIV/REMU ops, short-circuits special cases, sequences the iterative divider
// and returns results to the CDB; drains an in-flight divide on flush.
module div_issue_sequencer
  import div_seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic             iss_signed,
  input  logic [31:0]      iss_rs1,
  input  logic [31:0]      iss_rs2,
  input  logic [TAG_W-1:0] iss_tag,
  input  logic             flush,
  output logic             dv_valid_in,
  output logic             dv_div,
  output logic [31:0]      dv_dividend,
  output logic [31:0]      dv_divisor,
  input  logic             dv_ready,
  input  logic             dv_valid_out,
  input  logic [31:0]      dv_result,
  output logic             dv_yumi,
  output logic             cdb_req,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_value,
  input  logic             cdb_gnt,
  output logic             busy
);

  div_seq_state_t state;
  div_req_t       cur, head, push_req;
  logic [31:0]    res;
  logic           full, empty, push, pop;
  logic           special;
  logic [31:0]    spec_val, mag1, mag2;

  assign push_req = '{signed_op: iss_signed, rs1: iss_rs1, rs2: iss_rs2,
                      tag: DIV_TAG_W'(iss_tag)};

  assign iss_ready = !full && (state != S_DRAIN);
  assign push      = iss_valid && iss_ready && !flush;
  assign pop       = (state == S_IDLE) && !empty && !flush;

  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .din     (push_req),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  // Cases the divider would early-out on are answered here instead.
  always_comb begin
    mag1     = cur.signed_op ? abs32(cur.rs1) : cur.rs1;
    mag2     = cur.signed_op ? abs32(cur.rs2) : cur.rs2;
    special  = 1'b1;
    spec_val = '0;
    if (cur.rs2 == 32'd0)
      spec_val = cur.signed_op ? DIV_ZERO_Q : cur.rs1;
    else if (cur.signed_op && cur.rs1 == DIV_OVF_DIVIDEND && cur.rs2 == 32'hFFFF_FFFF)
      spec_val = DIV_OVF_DIVIDEND;
    else if (mag2 > mag1)
      spec_val = cur.signed_op ? 32'd0 : cur.rs1;
    else
      special = 1'b0;
  end

  assign dv_valid_in = (state == S_DISPATCH) && !special && dv_ready && !flush;
  assign dv_div      = cur.signed_op;
  assign dv_dividend = cur.rs1;
  assign dv_divisor  = cur.rs2;
  assign dv_yumi     = ((state == S_BUSY) || (state == S_DRAIN)) && dv_valid_out;
  assign cdb_req     = (state == S_RESULT) && !flush;
  assign cdb_tag     = TAG_W'(cur.tag);
  assign cdb_value   = res;
  assign busy        = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cur   <= '0;
      res   <= '0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          cur   <= head;
          state <= S_DISPATCH;
        end
        S_DISPATCH: begin
          if (flush) state <= S_IDLE;
          else if (special) begin
            res   <= spec_val;
            state <= S_RESULT;
          end else if (dv_ready) state <= S_BUSY;
        end
        S_BUSY: begin
          // A result arriving with flush is consumed and dropped; no drain needed.
          if (dv_valid_out) begin
            if (!flush) res <= dv_result;
            state <= flush ? S_IDLE : S_RESULT;
          end else if (flush) state <= S_DRAIN;
        end
        S_RESULT: if (flush || cdb_gnt) state <= S_IDLE;
        S_DRAIN:  if (dv_valid_out) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_sequencer.sv
// Directed bench: issue task pushes expected CDB results, a negedge monitor pops and compares.
module tb_div_issue_sequencer;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             iss_valid, iss_ready, iss_signed;
  logic [31:0]      iss_rs1, iss_rs2;
  logic [TAG_W-1:0] iss_tag;
  logic             flush;
  logic             dv_valid_in, dv_div, dv_ready, dv_valid_out, dv_yumi;
  logic [31:0]      dv_dividend, dv_divisor, dv_result;
  logic             cdb_req, cdb_gnt, busy;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  always #5 clk = ~clk;

  div_issue_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_signed(iss_signed),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_tag(iss_tag), .flush(flush),
    .dv_valid_in(dv_valid_in), .dv_div(dv_div), .dv_dividend(dv_dividend),
    .dv_divisor(dv_divisor), .dv_ready(dv_ready), .dv_valid_out(dv_valid_out),
    .dv_result(dv_result), .dv_yumi(dv_yumi),
    .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_gnt(cdb_gnt),
    .busy(busy)
  );

  int n_chk = 0, n_fail = 0, launches = 0, yumis = 0;
  logic gnt_en = 1'b0;
  assign cdb_gnt = gnt_en & cdb_req;

  typedef struct { logic [TAG_W-1:0] tag; logic [31:0] val; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Iterative divider stand-in: fixed latency, holds result until yumi.
  logic        dv_busy;
  int          dv_cnt;
  logic [31:0] dv_a, dv_b, dv_res;
  assign dv_ready  = ~dv_busy;
  assign dv_result = dv_res;

  always @(posedge clk) begin
    if (!reset_n) begin
      dv_busy <= 1'b0; dv_valid_out <= 1'b0; dv_cnt <= 0;
      dv_a <= '0; dv_b <= '0; dv_res <= '0;
    end else begin
      if (dv_valid_out && dv_yumi) begin
        dv_valid_out <= 1'b0; dv_busy <= 1'b0;
      end else if (dv_busy && !dv_valid_out) begin
        if (dv_cnt == 0) dv_valid_out <= 1'b1;
        else dv_cnt <= dv_cnt - 1;
      end
      if (dv_valid_in && dv_ready) begin
        dv_busy <= 1'b1; dv_cnt <= 3; dv_a <= dv_dividend; dv_b <= dv_divisor;
        if (dv_div) dv_res <= $signed(dv_dividend) / $signed(dv_divisor);
        else        dv_res <= dv_dividend % dv_divisor;
        launches++;
      end
    end
  end

  // Monitor: checks every CDB handoff against the scoreboard and operand stability.
  always @(negedge clk) begin
    if (reset_n) begin
      if (dv_yumi) yumis++;
      if (cdb_req && cdb_gnt) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cdb_unexpected: got tag %0d value %h expected no result", cdb_tag, cdb_value);
        end else begin
          mon_e = sb_q.pop_front();
          chk("cdb_tag", 32'(cdb_tag), 32'(mon_e.tag));
          chk("cdb_value", cdb_value, mon_e.val);
        end
      end
      if (dv_busy) begin
        chk("dv_dividend_stable", dv_dividend, dv_a);
        chk("dv_divisor_stable", dv_divisor, dv_b);
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t, input logic [31:0] exp);
    int n = 0;
    while (!iss_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!iss_ready) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: got iss_ready 0 expected 1 (tag %0d)", t);
    end else begin
      sb_q.push_back('{tag: t, val: exp});
      iss_valid = 1'b1; iss_signed = s; iss_rs1 = a; iss_rs2 = b; iss_tag = t;
      @(posedge clk); #1;
      iss_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 300) begin @(posedge clk); #1; n++; end
    if (busy || sb_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: got busy %0b pending %0d expected idle", busy, sb_q.size());
    end
  endtask

  // Special op from idle: cdb_req must rise exactly after the second edge past accept.
  task automatic spec_lat(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t, input logic [31:0] exp);
    wait_idle();
    issue(s, a, b, t, exp);
    @(posedge clk); #1; chk("spec_req_e1", 32'(cdb_req), 32'd0);
    @(posedge clk); #1; chk("spec_req_e2", 32'(cdb_req), 32'd1);
    wait_idle();
  endtask

  initial begin
    int l0, y0, n;
    logic saw_req;
    reset_n = 1'b0; iss_valid = 1'b0; iss_signed = 1'b0; iss_rs1 = '0; iss_rs2 = '0;
    iss_tag = '0; flush = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    chk("rst_cdb_req", 32'(cdb_req), 32'd0);
    chk("rst_dv_valid_in", 32'(dv_valid_in), 32'd0);
    chk("rst_dv_yumi", 32'(dv_yumi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dv_dividend", dv_dividend, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: DIV 50/5
    gnt_en = 1'b1; l0 = launches;
    issue(1'b1, 32'd50, 32'd5, 5'd3, 32'd10);
    @(posedge clk); #1; chk("t1_dv_valid_in", 32'(dv_valid_in), 32'd1);
    wait_idle();
    chk("t1_launches", 32'(launches - l0), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: signed quotients back-to-back
    l0 = launches;
    issue(1'b1, 32'hFFFF_FFCE, 32'd5, 5'd4, 32'hFFFF_FFF6);
    issue(1'b1, 32'd50, 32'hFFFF_FFFB, 5'd5, 32'hFFFF_FFF6);
    wait_idle();
    chk("t2_launches", 32'(launches - l0), 32'd2);

    // 3: divide-by-zero and overflow never reach the divider
    l0 = launches;
    spec_lat(1'b0, 32'd7, 32'd0, 5'd6, 32'd7);
    spec_lat(1'b1, 32'd7, 32'd0, 5'd7, 32'hFFFF_FFFF);
    spec_lat(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000);
    chk("t3_launches", 32'(launches - l0), 32'd0);

    // 4: divisor larger than dividend, then a real REMU
    l0 = launches;
    issue(1'b0, 32'd3, 32'd12345, 5'd9, 32'd3);
    issue(1'b1, 32'd0, 32'd9, 5'd10, 32'd0);
    wait_idle();
    chk("t4_no_launch", 32'(launches - l0), 32'd0);
    issue(1'b0, 32'd100, 32'd7, 5'd11, 32'd2);
    wait_idle();
    chk("t4_launch", 32'(launches - l0), 32'd1);

    // 5: back-pressure fills the FIFO
    gnt_en = 1'b0;
    issue(1'b1, 32'd100, 32'd10, 5'd12, 32'd10);
    issue(1'b0, 32'd9, 32'd4, 5'd13, 32'd1);
    issue(1'b0, 32'd1, 32'd2, 5'd14, 32'd1);
    chk("t5_full", 32'(iss_ready), 32'd0);
    repeat (8) @(posedge clk); #1;
    chk("t5_still_full", 32'(iss_ready), 32'd0);
    chk("t5_req_held", 32'(cdb_req), 32'd1);
    gnt_en = 1'b1;
    wait_idle();
    chk("t5_all_results", 32'(sb_q.size()), 32'd0);

    // 6: flush while the divider is busy with another op queued
    l0 = launches;
    issue(1'b0, 32'd100, 32'd7, 5'd15, 32'd2);
    n = 0;
    while (!dv_busy && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_launched", 32'(dv_busy), 32'd1);
    issue(1'b1, 32'd50, 32'd5, 5'd16, 32'd10);
    flush = 1'b1;
    iss_valid = 1'b1; iss_signed = 1'b1; iss_rs1 = 32'd60; iss_rs2 = 32'd6; iss_tag = 5'd17;
    @(posedge clk); #1;
    flush = 1'b0; iss_valid = 1'b0;
    sb_q.delete();
    y0 = yumis;
    chk("t6_drain_iss_ready", 32'(iss_ready), 32'd0);
    chk("t6_drain_busy", 32'(busy), 32'd1);
    saw_req = 1'b0; n = 0;
    while (busy && n < 40) begin
      if (cdb_req) saw_req = 1'b1;
      @(posedge clk); #1; n++;
    end
    repeat (6) begin
      if (cdb_req) saw_req = 1'b1;
      @(posedge clk); #1;
    end
    chk("t6_no_cdb_req", 32'(saw_req), 32'd0);
    chk("t6_yumi_once", 32'(yumis - y0), 32'd1);
    chk("t6_busy_low", 32'(busy), 32'd0);
    chk("t6_iss_ready", 32'(iss_ready), 32'd1);
    chk("t6_launches", 32'(launches - l0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
